// File: rtl/ifetch_seq.sv
// rtl/ifetch_seq.sv - multi-word instruction fetch sequencer over an MFC memory handshake
// Define FETCH_TIMEOUT_EN to abort a WAIT that sees no mfc for TIMEOUT cycles.
module ifetch_seq #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int IR_WORDS = 2,
   parameter int TIMEOUT  = 15
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       flush,
   input  logic                       pc_load,
   input  logic [ADDR_W-1:0]          pc_in,
   input  logic                       mfc,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic                       mem_en,
   output logic                       mem_rw,
   output logic [ADDR_W-1:0]          pc,
   output logic [DATA_W*IR_WORDS-1:0] ir,
   output logic                       ir_valid,
   output logic                       busy,
   output logic                       fetch_err
);
   localparam int IR_W  = DATA_W * IR_WORDS;
   localparam int CNT_W = $clog2(IR_WORDS + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_REQ, S_WAIT, S_CAPT, S_LOAD, S_DONE, S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, pc_start_q, pc_start_d, mar_q, mar_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic [IR_W-1:0]   asm_q, asm_d, ir_q, ir_d;
   logic [CNT_W-1:0]  wcnt_q, wcnt_d;
   logic              timeout;

`ifdef FETCH_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] tcnt_q, tcnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tcnt_q <= '0;
      else     tcnt_q <= tcnt_d;
   end

   // Cleared in REQ so it reads zero on the first WAIT cycle.
   always_comb begin
      tcnt_d = tcnt_q;
      if (state_q == S_REQ)                tcnt_d = '0;
      else if (state_q == S_WAIT && !mfc)  tcnt_d = tcnt_q + TO_W'(1);
   end

   assign timeout   = (tcnt_q == TO_W'(TIMEOUT - 1));
   assign fetch_err = (state_q == S_ERR);
`else
   assign timeout   = 1'b0;
   assign fetch_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         pc_start_q <= '0;
         mar_q      <= '0;
         mdr_q      <= '0;
         asm_q      <= '0;
         ir_q       <= '0;
         wcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_start_q <= pc_start_d;
         mar_q      <= mar_d;
         mdr_q      <= mdr_d;
         asm_q      <= asm_d;
         ir_q       <= ir_d;
         wcnt_q     <= wcnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pc_start_d = pc_start_q;
      mar_d      = mar_q;
      mdr_d      = mdr_q;
      asm_d      = asm_q;
      ir_d       = ir_q;
      wcnt_d     = wcnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (!flush) begin
               if (pc_load) begin
                  pc_d = pc_in;
               end else if (start) begin
                  pc_start_d = pc_q;
                  wcnt_d     = '0;
                  state_d    = S_ADDR;
               end
            end
         end
         S_ADDR: begin
            mar_d   = pc_q;
            state_d = S_REQ;
         end
         S_REQ: state_d = S_WAIT;
         S_WAIT: begin
            if (mfc) begin
               mdr_d   = mem_rdata;
               state_d = S_CAPT;
            end else if (timeout) begin
               pc_d    = pc_start_q;
               state_d = S_ERR;
            end
         end
         S_CAPT: begin
            // First word fetched drifts up to the most-significant slice.
            asm_d   = (asm_q << DATA_W) | IR_W'(mdr_q);
            pc_d    = pc_q + ADDR_W'(1);
            wcnt_d  = wcnt_q + CNT_W'(1);
            state_d = (wcnt_q == CNT_W'(IR_WORDS - 1)) ? S_LOAD : S_ADDR;
         end
         S_LOAD: begin
            ir_d    = asm_q;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d = S_IDLE;
         ir_d    = ir_q;
         pc_d    = (state_q == S_IDLE) ? pc_q : pc_start_q;
      end
   end

   assign mem_addr = mar_q;
   assign mem_en   = (state_q == S_REQ) || (state_q == S_WAIT);
   assign mem_rw   = (state_q == S_WAIT);
   assign pc       = pc_q;
   assign ir       = ir_q;
   assign ir_valid = (state_q == S_DONE);
   assign busy     = (state_q != S_IDLE);
endmodule
